parking_slot_manager: RTL
=========================

Name: parking_slot_manager

Overview:
- Upstream stage of the parking display.
- Debounces the four raw slot-occupancy sensors and keeps the registered occupancy map.
- Derives free-slot count (capacity), lowest free slot index (first_empty) and a full flag for the display.
- Runs the entry-gate state machine: opens the barrier only when a slot is free.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive stable samples needed to accept a sensor change (40 ms at 500 Hz); legal range 2..255
GATE_OPEN_CYCLES, 1500, cycles the gate stays open after a granted entry (3 s at 500 Hz); legal range 2..4095

Ports:
clk_500Hz  input  1  system clock, 500 Hz, rising edge
reset  input  1  asynchronous, active-low reset
slot_sensor  input  4  raw slot sensors, 1 = occupied, asynchronous and bouncy; bit i = slot i
entry_req  input  1  raw entry-loop detector, 1 = car at gate, asynchronous level
capacity  output  3  number of free slots, 0..4, registered
first_empty  output  2  lowest-index free slot; 0 when full, registered
full  output  1  1 when capacity == 0, registered
gate_open  output  1  barrier drive, 1 = open, registered
entry_denied  output  1  one-cycle pulse: arrival refused because lot is full

Behaviour:
- Reset (reset == 0, asynchronous) clears all state:
  - occupied = 4'b0000; debounce counters = 0; synchronizers = 0; edge register = 0; FSM = IDLE.
  - Output reset values: capacity = 3'd4, first_empty = 2'd0, full = 0, gate_open = 0, entry_denied = 0.
- Synchronizers: slot_sensor and entry_req each pass through 2 flops. s_sync and r_sync are the second-stage values.
- Debounce, per slot i, every cycle:
  - If s_sync[i] == occupied[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: occupied[i] <= s_sync[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes occupied.
  - Slots are independent; simultaneous changes on several slots are all accepted.
- Status outputs, registered from occupied with 1-cycle latency:
  - capacity = count of zero bits in occupied (3-bit, max 4).
  - first_empty = lowest i with occupied[i] == 0; 2'd0 when all occupied.
  - full = (occupied == 4'b1111).
  - End-to-end latency, stable sensor edge to capacity update: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Arrival edge: arrive = r_sync & ~r_prev. r_prev resets to 0, so a request held high through reset counts as a new arrival.
- Gate FSM states: IDLE, OPEN, HOLD.
  - IDLE, arrive and full == 0: go to OPEN, load timer = GATE_OPEN_CYCLES-1, gate_open = 1 from the next cycle.
  - IDLE, arrive and full == 1: stay in IDLE; entry_denied = 1 for exactly one cycle.
  - OPEN: timer decrements each cycle. At timer == 0, go to HOLD if r_sync == 1, else IDLE. Gate is open for exactly GATE_OPEN_CYCLES cycles when the car has already left.
  - HOLD: stay while r_sync == 1 (car under the barrier); go to IDLE the cycle after r_sync == 0.
  - gate_open = 1 in OPEN and HOLD, 0 in IDLE (registered state decode).
- Boundary rules:
  - Arrivals during OPEN or HOLD are ignored: no denial pulse, timer not reloaded.
  - full asserting while OPEN or HOLD does not close the gate.
  - Lot transitioning full to not-full has no effect on an earlier denial; the car must re-trigger with a new rising edge.
  - Reset asserted mid-open closes the gate asynchronously (gate_open = 0 immediately).
- No arithmetic overflow: capacity ≤ 4 fits 3 bits; timer width = clog2(GATE_OPEN_CYCLES).

Test Plan (bench uses DEBOUNCE_CYCLES = 4, GATE_OPEN_CYCLES = 10):
- Reset release with slot_sensor = 0000 -> capacity = 4, first_empty = 0, full = 0, gate_open = 0; outputs stay unchanged over 20 cycles.
- Set slot_sensor = 0011, held -> capacity = 2 and first_empty = 2 exactly 7 cycles after the change. Then a 2-cycle pulse of bit 2 -> no output change.
- Set slot_sensor = 1111 -> full = 1, capacity = 0, first_empty = 0. Then a 3-cycle entry_req pulse -> one entry_denied pulse, gate_open stays 0.
- Set slot_sensor = 1011, then a 3-cycle entry_req pulse -> capacity = 1, first_empty = 2; gate_open high for exactly 10 cycles, then 0.
- entry_req held high for 30 cycles with lot not full -> gate_open stays 1 through HOLD; drops 4 cycles after entry_req falls (2 sync + HOLD exit + registered state). A second rising edge during OPEN is ignored.
- Assert reset 5 cycles into OPEN -> gate_open = 0 and capacity = 4 immediately. After release, occupancy re-debounces from the sensors.

Source files
------------

// File: rtl/parking_slot_manager.sv
// Parking slot manager: synchronizes and debounces four slot sensors, keeps the
// registered occupancy map, derives free-slot status for the display and runs
// the entry-gate state machine that only opens the barrier when a slot is free.
module parking_slot_manager #(
  parameter int DEBOUNCE_CYCLES  = 20,
  parameter int GATE_OPEN_CYCLES = 1500
) (
  input  logic       clk_500Hz,
  input  logic       reset,
  input  logic [3:0] slot_sensor,
  input  logic       entry_req,
  output logic [2:0] capacity,
  output logic [1:0] first_empty,
  output logic       full,
  output logic       gate_open,
  output logic       entry_denied
);

  localparam int              TW      = $clog2(GATE_OPEN_CYCLES);
  localparam logic [7:0]      DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]   T_LOAD  = TW'(GATE_OPEN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_HOLD = 2'd2
  } gate_state_t;

  logic [3:0]    r_s_meta, r_s_sync;
  logic          r_r_meta, r_r_sync, r_r_prev;
  logic [3:0]    r_occupied;
  logic [7:0]    r_cnt [4];
  logic [2:0]    r_capacity;
  logic [1:0]    r_first_empty;
  logic          r_full;
  gate_state_t   r_state;
  logic [TW-1:0] r_timer;
  logic          r_gate_open;
  logic          r_entry_denied;

  logic [2:0]    w_free_cnt;
  logic [1:0]    w_first_empty;
  logic          w_arrive;

  // Two-flop synchronizers for the asynchronous sensor and loop inputs, plus
  // the previous-sample register used for arrival edge detection.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      r_s_meta <= '0;
      r_s_sync <= '0;
      r_r_meta <= 1'b0;
      r_r_sync <= 1'b0;
      r_r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its neighbour, which is what turns these lines into a shift chain.
      r_s_meta <= slot_sensor;
      r_s_sync <= r_s_meta;
      r_r_meta <= entry_req;
      r_r_sync <= r_r_meta;
      r_r_prev <= r_r_sync;
    end
  end

  // Per-slot debounce: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples disagree with the stored occupancy.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      r_occupied <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_s_sync[i] == r_occupied[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_occupied[i] <= r_s_sync[i];
          r_cnt[i]      <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Free-slot count and lowest free index from the occupancy map.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch forms.
    w_free_cnt    = '0;
    w_first_empty = 2'd0;
    for (int i = 0; i < 4; i++) w_free_cnt = w_free_cnt + {2'b00, ~r_occupied[i]};
    for (int i = 3; i >= 0; i--) begin
      if (!r_occupied[i]) w_first_empty = 2'(i);
    end
  end

  // Registered status outputs, one cycle behind the occupancy map.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      r_capacity    <= 3'd4;
      r_first_empty <= 2'd0;
      r_full        <= 1'b0;
    end else begin
      r_capacity    <= w_free_cnt;
      r_first_empty <= w_first_empty;
      r_full        <= (r_occupied == 4'b1111);
    end
  end

  assign w_arrive = r_r_sync & ~r_r_prev;

  // Entry-gate FSM with open timer, denial pulse and registered gate decode.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_gate_open    <= 1'b0;
      r_entry_denied <= 1'b0;
    end else begin
      r_entry_denied <= 1'b0;
      r_gate_open    <= (r_state != ST_IDLE);
      unique case (r_state)
        ST_IDLE: begin
          if (w_arrive && !r_full) begin
            r_state <= ST_OPEN;
            r_timer <= T_LOAD;
          end else if (w_arrive) begin
            r_entry_denied <= 1'b1;
          end
        end
        ST_OPEN: begin
          // Arrivals here are ignored; the timer is never reloaded.
          if (r_timer == '0) r_state <= r_r_sync ? ST_HOLD : ST_IDLE;
          else               r_timer <= r_timer - 1'b1;
        end
        ST_HOLD: begin
          if (!r_r_sync) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign capacity     = r_capacity;
  assign first_empty  = r_first_empty;
  assign full         = r_full;
  assign gate_open    = r_gate_open;
  assign entry_denied = r_entry_denied;

endmodule
